// File: rtl/clk_rst_seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_rst_seq_gen_pkg                                             |
// | Purpose  : Shared types and constants for the clock/reset sequence         |
// |            generator: sequencer state enum, reset synchroniser depth and   |
// |            a width helper for counters sized from parameters.              |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package clk_rst_seq_gen_pkg;

  // Number of flops in the rst_n deassertion synchroniser.
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RUN     = 2'd3
  } seq_state_e;

  // Bits needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_rst_seq_gen_div_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_div_ch                                                      |
// | Purpose  : One divided-clock channel. Counts 0..D-1 while running; at D-1  |
// |            it wraps, toggles clk_div and pulses tick for one cycle, giving |
// |            a 50% duty clock of period 2*D. D=0 or run=0 idles the channel  |
// |            with everything cleared.                                        |
// | Ports    : clk      - rising-edge clock                                    |
// |            rst_n    - asynchronous active-low reset                        |
// |            run      - channel released, enabled and not in soft reset      |
// |            div      - divide ratio D                                       |
// |            clk_div  - divided clock                                        |
// |            tick     - one-cycle pulse coincident with each clk_div toggle  |
// | Macro    : CLK_RST_SEQ_GEN_DIV_LATCH_EN - sample div only at period starts |
// |            (enable rise and after every wrap) instead of comparing live.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_div_ch #(
  parameter int G_DIV_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [G_DIV_W-1:0] div,
  output logic               clk_div,
  output logic               tick
);

  localparam logic [G_DIV_W-1:0] DIV_ONE = G_DIV_W'(1);

  logic [G_DIV_W-1:0] cnt_q;
  logic [G_DIV_W-1:0] d_eff;
  logic               active;
  logic               wrap;

`ifdef CLK_RST_SEQ_GEN_DIV_LATCH_EN
  // start_q marks the first cycle of a period (after idle or right after a
  // wrap); only then is div sampled, so mid-period changes wait for the
  // next boundary.
  logic [G_DIV_W-1:0] d_q;
  logic               start_q;

  assign d_eff = start_q ? div : d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      start_q <= 1'b1;
    end else if (!active) begin
      start_q <= 1'b1;
    end else begin
      d_q     <= d_eff;
      start_q <= wrap;
    end
  end
`else
  // Live compare: a ratio lowered below the current count wraps next cycle.
  assign d_eff = div;
`endif

  assign active = run && (d_eff != '0);
  assign wrap   = active && (cnt_q >= (d_eff - DIV_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else if (!active) begin
      cnt_q   <= '0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      cnt_q   <= '0;
      clk_div <= ~clk_div;
      tick    <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + DIV_ONE;
      tick    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_rst_seq_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clk_rst_seq_gen                                                 |
// | Purpose  : Reset sequencer plus per-channel clock dividers. After rst_n    |
// |            deasserts (2-flop synchronised) the channel resets are held for |
// |            G_RST_CYCLES cycles, then released one by one G_RST_STAGGER     |
// |            cycles apart. sw_rst_i restarts the sequence from the hold.     |
// | Ports    : clk_tb     - clock, rising edge                                 |
// |            rst_n      - asynchronous active-low reset                      |
// |            sw_rst_i   - synchronous soft reset                             |
// |            en_i       - per-channel divider enable                         |
// |            div_i      - packed divide ratios, channel i at [i*W +: W]      |
// |            rst_n_o    - per-channel active-low reset                       |
// |            clk_div_o  - per-channel divided clock                          |
// |            tick_o     - per-channel toggle pulse                           |
// |            seq_done_o - all channels released                              |
// | Macro    : CLK_RST_SEQ_GEN_DIV_LATCH_EN - latch divide ratios per period   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clk_rst_seq_gen
  import clk_rst_seq_gen_pkg::*;
#(
  parameter int G_NB_CH       = 4,
  parameter int G_DIV_W       = 8,
  parameter int G_RST_CYCLES  = 16,
  parameter int G_RST_STAGGER = 4
) (
  input  logic                       clk_tb,
  input  logic                       rst_n,
  input  logic                       sw_rst_i,
  input  logic [G_NB_CH-1:0]         en_i,
  input  logic [G_NB_CH*G_DIV_W-1:0] div_i,
  output logic [G_NB_CH-1:0]         rst_n_o,
  output logic [G_NB_CH-1:0]         clk_div_o,
  output logic [G_NB_CH-1:0]         tick_o,
  output logic                       seq_done_o
);

  localparam int HOLD_CW = clog2_min1(G_RST_CYCLES);
  localparam int STG_CW  = clog2_min1(G_RST_STAGGER);
  localparam int IDX_CW  = clog2_min1(G_NB_CH);

  localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(G_RST_CYCLES - 1);
  localparam logic [HOLD_CW-1:0] HOLD_ONE  = HOLD_CW'(1);
  localparam logic [STG_CW-1:0]  STG_LAST  = STG_CW'((G_RST_STAGGER > 0) ? G_RST_STAGGER - 1 : 0);
  localparam logic [STG_CW-1:0]  STG_ONE   = STG_CW'(1);
  localparam logic [IDX_CW-1:0]  IDX_LAST  = IDX_CW'(G_NB_CH - 1);
  localparam logic [IDX_CW-1:0]  IDX_ONE   = IDX_CW'(1);
  localparam logic [G_NB_CH-1:0] REL_CH0   = G_NB_CH'(1);
  localparam bit                 REL_ALL   = (G_RST_STAGGER == 0) || (G_NB_CH == 1);

  // ---------------------------------------------------------------- sync
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  rst_sync;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
  end

  assign rst_sync = sync_q[SYNC_DEPTH-1];

  // ----------------------------------------------------------- sequencer
  seq_state_e           state_q, state_d;
  logic [HOLD_CW-1:0]   hold_q,  hold_d;
  logic [STG_CW-1:0]    stg_q,   stg_d;
  logic [IDX_CW-1:0]    idx_q,   idx_d;
  logic [G_NB_CH-1:0]   rel_q,   rel_d;
  logic                 go_release;

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      hold_q  <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stg_d      = stg_q;
    idx_d      = idx_q;
    rel_d      = rel_q;
    go_release = 1'b0;

    if (rst_sync) begin
      if (sw_rst_i) begin
        state_d = S_HOLD;
        hold_d  = '0;
        stg_d   = '0;
        idx_d   = '0;
        rel_d   = '0;
      end else begin
        case (state_q)
          // The first cycle with the synchronised reset released is already
          // hold cycle 0, so the hold ends G_RST_CYCLES cycles after the
          // synchroniser output rises.
          S_RESET: begin
            if (G_RST_CYCLES == 1) begin
              go_release = 1'b1;
            end else begin
              state_d = S_HOLD;
              hold_d  = HOLD_ONE;
            end
          end
          S_HOLD: begin
            if (hold_q == HOLD_LAST) go_release = 1'b1;
            else                     hold_d     = hold_q + HOLD_ONE;
          end
          S_RELEASE: begin
            if (stg_q == STG_LAST) begin
              rel_d[idx_q] = 1'b1;
              stg_d        = '0;
              if (idx_q == IDX_LAST) state_d = S_RUN;
              else                   idx_d   = idx_q + IDX_ONE;
            end else begin
              stg_d = stg_q + STG_ONE;
            end
          end
          S_RUN: begin
          end
          default: state_d = S_RESET;
        endcase
      end
    end

    if (go_release) begin
      if (REL_ALL) begin
        rel_d   = '1;
        state_d = S_RUN;
      end else begin
        rel_d   = REL_CH0;
        idx_d   = IDX_ONE;
        stg_d   = '0;
        state_d = S_RELEASE;
      end
    end
  end

  assign rst_n_o    = rel_q;
  assign seq_done_o = (state_q == S_RUN);

  // ------------------------------------------------------------ channels
  // sw_rst_i gates run directly so the dividers clear on the same edge that
  // drops the channel resets.
  for (genvar i = 0; i < G_NB_CH; i++) begin : g_ch
    clk_div_ch #(
      .G_DIV_W (G_DIV_W)
    ) u_ch (
      .clk     (clk_tb),
      .rst_n   (rst_n),
      .run     (rel_q[i] & en_i[i] & ~sw_rst_i),
      .div     (div_i[i*G_DIV_W +: G_DIV_W]),
      .clk_div (clk_div_o[i]),
      .tick    (tick_o[i])
    );
  end

endmodule
`default_nettype wire

// File: doc/clk_rst_seq_gen.md
CLK_RST_SEQ_GEN -- requirements
Module: clk_rst_seq_gen

Interface
REQ-001 SHALL have parameter G_NB_CH, default 4: number of output channels (1..16).
REQ-002 SHALL have parameter G_DIV_W, default 8: divide-ratio width per channel.
REQ-003 SHALL have parameter G_RST_CYCLES, default 16: hold cycles after reset deassert (>=1).
REQ-004 SHALL have parameter G_RST_STAGGER, default 4: cycles between successive channel releases (0 = simultaneous).
REQ-005 SHALL have port clk_tb  in  1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous active-low reset.
REQ-007 SHALL have port sw_rst_i  in  1: synchronous soft reset, restarts the sequence.
REQ-008 SHALL have port en_i  in  G_NB_CH: per-channel divider enable.
REQ-009 SHALL have port div_i  in  G_NB_CH*G_DIV_W: packed divide ratios; channel i at bits [i*G_DIV_W +: G_DIV_W].
REQ-010 SHALL have port rst_n_o  out  G_NB_CH: per-channel active-low reset.
REQ-011 SHALL have port clk_div_o  out  G_NB_CH: per-channel divided clock, 50% duty.
REQ-012 SHALL have port tick_o  out  G_NB_CH: one-cycle pulse at each clk_div_o toggle.
REQ-013 SHALL have port seq_done_o  out  1: high once all channels are released.

Function
REQ-014 SHALL synchronise rst_n deassertion through a 2-flop synchroniser; internal reset releases 2 cycles after rst_n rises.
REQ-015 SHALL implement FSM states S_RESET, S_HOLD, S_RELEASE, S_RUN.
REQ-016 S_RESET -> S_HOLD on the first cycle with the synchronised reset released.
REQ-017 S_HOLD SHALL count G_RST_CYCLES cycles, then -> S_RELEASE with channel 0 released on the transition cycle.
REQ-018 S_RELEASE SHALL release channel k+1 G_RST_STAGGER cycles after channel k; after the last channel -> S_RUN; with G_RST_STAGGER=0 all channels release in one cycle.
REQ-019 seq_done_o SHALL be 1 only in S_RUN.
REQ-020 sw_rst_i=1 in any state SHALL, on the next edge, drive all rst_n_o low, clear dividers and counters, and enter S_HOLD; sw_rst_i held high keeps S_HOLD's counter at 0.
REQ-021 Per channel, the divider SHALL run only when rst_n_o[i]=1 and en_i[i]=1; otherwise counter=0, clk_div_o[i]=0, tick_o[i]=0.
REQ-022 Running divider with ratio D>=1 SHALL count 0..D-1, and at D-1 wrap to 0, toggle clk_div_o[i], and pulse tick_o[i] in the same cycle; output period is 2*D clk_tb cycles.
REQ-023 First toggle SHALL occur D cycles after enable rises (clk_div_o high).
REQ-024 D=0 SHALL be treated as disabled (REQ-021 behaviour).
REQ-025 Dropping en_i[i] mid-period SHALL clear the channel on the next edge without a final tick.

Reset
REQ-026 rst_n low SHALL asynchronously force rst_n_o=0, clk_div_o=0, tick_o=0, seq_done_o=0, FSM=S_RESET, all counters 0.

Configuration
REQ-027 With CLK_RST_SEQ_GEN_DIV_LATCH_EN defined, each channel SHALL latch div_i on enable rise and at every wrap; changes take effect only at the next period boundary.
REQ-028 Without CLK_RST_SEQ_GEN_DIV_LATCH_EN, div_i SHALL be compared live; if the counter is >= the new D-1, wrap occurs on the next cycle.

Structure
REQ-029 Shared package clk_rst_seq_gen_pkg SHALL hold the FSM state enum and the synchroniser depth constant (2).
REQ-030 The per-channel divider SHALL be sub-module clk_div_ch, instantiated G_NB_CH times in a generate loop.

Verification
REQ-031 rst_n rises at t0, defaults -> rst_n_o[0] rises 2+16 cycles later; channels 1,2,3 at +4,+8,+12; seq_done_o rises with channel 3.
REQ-032 After S_RUN, en_i=4'b0001, D=3 -> clk_div_o[0] period 6 cycles, tick_o[0] every 3 cycles, first tick 3 cycles after enable.
REQ-033 sw_rst_i pulsed 1 cycle in S_RUN -> all rst_n_o low and seq_done_o low next cycle; full 16+12-cycle sequence replays.
REQ-034 rst_n asserted mid-S_RELEASE -> all outputs 0 immediately, no clock edge required.
REQ-035 D changed 5->2 mid-period: with macro, current half-period completes at 5 cycles, next is 2; without macro, wrap on next cycle if counter >= 1.
REQ-036 G_RST_STAGGER=0, D=0 on channel 1 with en_i=1 -> all channels release together; clk_div_o[1] stays 0 and tick_o[1] never pulses.
